// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the flappy game datapath: screen geometry, the
// colour codes the object modules use, and the state encoding of the sprite
// plotter FSM.
// -----------------------------------------------------------------------------
package flappy_pkg;

  // Visible screen area of the VGA adapter, in pixels
  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  // 3-bit RGB colour codes; black doubles as the erase colour
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_PINK  = 3'b101;

  // Sprite plotter states: waiting for a new triple, emitting pixels,
  // and a one-cycle gap before the next triple is considered
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } plot_state_t;

endpackage

// File: rtl/sprite_plotter_if.sv
// -----------------------------------------------------------------------------
// sprite_plotter_if
// Bundles the object-side coordinate/colour triple and the adapter-side pixel
// write stream of the sprite plotter.
//   in_x, in_y, in_colour     : sprite top-left corner and colour (object side)
//   vga_x, vga_y, vga_colour  : pixel address and colour (adapter side)
//   vga_plot                  : adapter writeEn, one pixel per cycle high
//   busy                      : high while a sprite is being emitted
// master = object module / bench side, slave = the plotter itself.
// -----------------------------------------------------------------------------
interface sprite_plotter_if;

  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  modport master (
    output in_x, in_y, in_colour,
    input  vga_x, vga_y, vga_colour, vga_plot, busy
  );

  modport slave (
    input  in_x, in_y, in_colour,
    output vga_x, vga_y, vga_colour, vga_plot, busy
  );

endinterface

// File: rtl/sprite_plotter_offset_counter.sv
// -----------------------------------------------------------------------------
// sprite_offset_counter
// Nested offset counter that walks a SIZE x SIZE sprite in row-major order:
// dx runs fastest and wraps into dy.
//   clk50, reset : clock and asynchronous active-high reset
//   clear        : synchronously return both offsets to zero
//   enable       : advance one pixel this cycle
//   dx, dy       : current column / row offset inside the sprite
//   last         : current offset is the bottom-right pixel
// -----------------------------------------------------------------------------
module sprite_offset_counter #(
  parameter int SIZE = 4
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  localparam logic [2:0] MAX_OFF = 3'(SIZE - 1);

  logic row_end;

  assign row_end = (dx == MAX_OFF);
  assign last    = row_end && (dy == MAX_OFF);

  // Offset registers: clear has priority over enable so the FSM can park the
  // counter at the origin while it waits for the next sprite.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      dx <= 3'd0;
      dy <= 3'd0;
    end else if (clear) begin
      dx <= 3'd0;
      dy <= 3'd0;
    end else if (enable) begin
      if (row_end) begin
        dx <= 3'd0;
        dy <= (dy == MAX_OFF) ? 3'd0 : dy + 3'd1;
      end else begin
        dx <= dx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// -----------------------------------------------------------------------------
// sprite_plotter
// Turns the x/y/colour triple an object module presents into a stream of
// single-pixel writes for the VGA adapter. Any change of the triple draws one
// SIZE x SIZE square at (x, y); pixels that fall off screen are suppressed
// but still take their cycle, so every sprite lasts the same time.
//   clk50, reset : 50 MHz clock and asynchronous active-high reset
//   bus          : slave side of sprite_plotter_if (triple in, pixels out)
// -----------------------------------------------------------------------------
module sprite_plotter #(
  parameter int SIZE  = 4,
  parameter int X_MAX = flappy_pkg::X_MAX,
  parameter int Y_MAX = flappy_pkg::Y_MAX
) (
  input logic              clk50,
  input logic              reset,
  sprite_plotter_if.slave  bus
);

  import flappy_pkg::*;

  plot_state_t state, next_state;

  logic [7:0] sx;
  logic [6:0] sy;
  logic [2:0] scol;
  logic [2:0] dx, dy;
  logic       last_pixel;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       triple_changed;
  logic [8:0] px;
  logic [7:0] py;
  logic       in_bounds;

  sprite_offset_counter #(.SIZE(SIZE)) u_offset (
    .clk50  (clk50),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .dx     (dx),
    .dy     (dy),
    .last   (last_pixel)
  );

  assign triple_changed = {bus.in_x, bus.in_y, bus.in_colour} != {sx, sy, scol};

  // Sums are one bit wider than the screen coordinates so a sprite near the
  // right/bottom edge is clipped instead of wrapping to the opposite side.
  assign px        = {1'b0, sx} + {6'b0, dx};
  assign py        = {1'b0, sy} + {5'b0, dy};
  assign in_bounds = (px < 9'(X_MAX)) && (py < 8'(Y_MAX));

  // State register
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Shadow of the last accepted triple; only sampled while idle, so changes
  // arriving mid-sprite wait and only the newest one is picked up.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sx   <= 8'd0;
      sy   <= 7'd0;
      scol <= 3'd0;
    end else if (state == IDLE && triple_changed) begin
      sx   <= bus.in_x;
      sy   <= bus.in_y;
      scol <= bus.in_colour;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (triple_changed) next_state = PLOT;
      PLOT:    if (last_pixel)     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: the counter is held at the origin whenever idle and runs only
  // while plotting; the pixel stream is a pure function of registered state.
  always_comb begin
    cnt_clear      = (state == IDLE);
    cnt_enable     = (state == PLOT);
    bus.vga_x      = px[7:0];
    bus.vga_y      = py[6:0];
    bus.vga_colour = scol;
    bus.vga_plot   = (state == PLOT) && in_bounds;
    bus.busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// -----------------------------------------------------------------------------
// tb_sprite_plotter
// Self-checking bench for sprite_plotter. Expected pixels are pushed to a
// scoreboard queue when a triple is driven and popped by a monitor every
// cycle the plotter asserts vga_plot.
// -----------------------------------------------------------------------------
module tb_sprite_plotter;

  import flappy_pkg::*;

  localparam int SIZE = 4;

  logic clk50;
  logic reset;
  int   checks;
  int   errors;
  int   plot_count;
  int   sprite_starts;
  logic prev_busy;
  logic [17:0] sb[$];

  sprite_plotter_if bus ();

  sprite_plotter #(.SIZE(SIZE)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  // 50 MHz clock
  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every plotted pixel must be the next one the scoreboard expects
  always @(negedge clk50) begin
    if (!reset && bus.vga_plot === 1'b1) begin
      plot_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_plot", {bus.vga_x, bus.vga_y, bus.vga_colour}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, sb.pop_front());
      end
    end
    if (bus.busy === 1'b1 && prev_busy !== 1'b1) sprite_starts++;
    prev_busy = bus.busy;
  end

  // Expected pixels of one sprite in raster order, clipped to the screen;
  // limit cuts the sprite off after that many raster positions
  task automatic pushSprite(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c, input int limit);
    int n;
    int px;
    int py;
    n = 0;
    for (int r = 0; r < SIZE; r++) begin
      for (int q = 0; q < SIZE; q++) begin
        px = int'(x) + q;
        py = int'(y) + r;
        if (n < limit && px < X_MAX && py < Y_MAX) sb.push_back({px[7:0], py[6:0], c});
        n++;
      end
    end
  endtask

  // Follows one sprite from the cycle after the triple is taken until busy
  // drops, checking latency, duration and the silent DONE cycle
  task automatic waitSprite();
    int   len;
    logic last_plot;
    len       = 0;
    last_plot = 1'b0;
    @(negedge clk50);
    checkOutput("first_busy", bus.busy, 1);
    while (bus.busy === 1'b1 && len < 100) begin
      last_plot = bus.vga_plot;
      len++;
      @(negedge clk50);
    end
    checkOutput("busy_len", len, SIZE * SIZE + 1);
    checkOutput("done_plot", last_plot, 0);
    checkOutput("sb_empty", sb.size(), 0);
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    @(negedge clk50);
    #1;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_colour = c;
  endtask

  task automatic runSprite(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    applyStimulus(x, y, c);
    pushSprite(x, y, c, SIZE * SIZE);
    waitSprite();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_plot"}, bus.vga_plot, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_pixel"}, {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
  endtask

  initial begin
    int plots0;
    int starts0;
    int n;
    int guard;

    checks        = 0;
    errors        = 0;
    plot_count    = 0;
    sprite_starts = 0;
    prev_busy     = 1'b0;
    reset         = 1'b1;
    bus.in_x      = 8'd0;
    bus.in_y      = 7'd0;
    bus.in_colour = COL_BLACK;

    repeat (3) @(negedge clk50);
    #1 reset = 1'b0;
    @(negedge clk50);
    checkResetState("reset");

    // Basic sprite, then a long quiet hold with unchanged inputs
    plots0 = plot_count;
    runSprite(8'd10, 7'd20, COL_PINK);
    checkOutput("basic_plots", plot_count - plots0, 16);
    plots0 = plot_count;
    repeat (1000) @(negedge clk50);
    checkOutput("hold_plots", plot_count - plots0, 0);

    // Bottom-right corner: only four pixels land on screen
    plots0 = plot_count;
    runSprite(8'd158, 7'd118, COL_PINK);
    checkOutput("clip_plots", plot_count - plots0, 4);

    // Two changes during a sprite: only the newest triple is drawn afterwards
    starts0 = sprite_starts;
    applyStimulus(8'd40, 7'd50, COL_PINK);
    pushSprite(8'd40, 7'd50, COL_PINK, SIZE * SIZE);
    n     = 0;
    guard = 0;
    while (n < 5 && guard < 50) begin
      @(negedge clk50);
      if (bus.vga_plot === 1'b1) n++;
      guard++;
    end
    checkOutput("mid_sprite_reached", n, 5);
    #1 bus.in_colour = COL_BLACK;
    @(negedge clk50);
    #1 bus.in_x = 8'd11;
    pushSprite(8'd11, 7'd50, COL_BLACK, SIZE * SIZE);
    repeat (120) @(negedge clk50);
    checkOutput("latest_wins_sprites", sprite_starts - starts0, 2);
    checkOutput("latest_wins_sb", sb.size(), 0);
    checkOutput("latest_wins_idle", bus.busy, 0);

    // Reset in the middle of a sprite, then restart with the same inputs
    applyStimulus(8'd70, 7'd30, COL_PINK);
    pushSprite(8'd70, 7'd30, COL_PINK, 7);
    n     = 0;
    guard = 0;
    while (n < 7 && guard < 50) begin
      @(negedge clk50);
      if (bus.vga_plot === 1'b1) n++;
      guard++;
    end
    checkOutput("abort_reached", n, 7);
    #1 reset = 1'b1;
    @(negedge clk50);
    checkResetState("abort");
    checkOutput("abort_sb", sb.size(), 0);
    #1 reset = 1'b0;
    pushSprite(8'd70, 7'd30, COL_PINK, SIZE * SIZE);
    waitSprite();

    // All-zero triple after reset matches the cleared shadow: nothing drawn
    @(negedge clk50);
    #1 reset = 1'b1;
    bus.in_x      = 8'd0;
    bus.in_y      = 7'd0;
    bus.in_colour = COL_BLACK;
    @(negedge clk50);
    #1 reset = 1'b0;
    starts0 = sprite_starts;
    repeat (30) @(negedge clk50);
    checkOutput("zero_no_sprite", sprite_starts - starts0, 0);
    plots0 = plot_count;
    runSprite(8'd0, 7'd0, COL_PINK);
    checkOutput("origin_plots", plot_count - plots0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
